// File: rtl/exu_wbck_arb_pkg.sv
// Shared constants and types for the EXU writeback arbiter.
// Mirrors the E203 defines for data width, register index width and starvation bound.
package exu_wbck_arb_pkg;

    localparam int E203_XLEN            = 32;
    localparam int E203_RFIDX_WIDTH     = 5;
    localparam int E203_WBCK_STARVE_MAX = 7;

    // Which rule selected this cycle's winner.
    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_STARVE = 2'd1,
        SRC_ALU    = 2'd2,
        SRC_RR     = 2'd3
    } grant_src_e;

    // Bits needed to hold values 0..n-1 (never less than one bit).
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/exu_wbck_arb_if.sv
// Writeback requester bundle plus the register-file write port.
// The arbiter takes the slave view; requesters and the register file take the master view.
interface exu_wbck_arb_if #(
    parameter int NREQ    = 4,
    parameter int XLEN    = exu_wbck_arb_pkg::E203_XLEN,
    parameter int RFIDX_W = exu_wbck_arb_pkg::E203_RFIDX_WIDTH
);
    // A write transfers on a rising edge where req_valid[i] and req_ready[i] are both high;
    // once raised, req_valid[i] and its idx/dat slices hold until that transfer.
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*RFIDX_W-1:0] req_idx;
    logic [NREQ*XLEN-1:0]    req_dat;
    logic                    wbck_dest_wen;
    logic [RFIDX_W-1:0]      wbck_dest_idx;
    logic [XLEN-1:0]         wbck_dest_dat;
    logic                    starve_evt;

    modport master (
        output req_valid, req_idx, req_dat,
        input  req_ready, wbck_dest_wen, wbck_dest_idx, wbck_dest_dat, starve_evt
    );

    modport slave (
        input  req_valid, req_idx, req_dat,
        output req_ready, wbck_dest_wen, wbck_dest_idx, wbck_dest_dat, starve_evt
    );
endinterface

// File: rtl/exu_wbck_rr_pick.sv
// Combinational round-robin pick: first set valid bit at or after start_i, wrapping,
// returned one-hot. start_i must be below N.
module exu_wbck_rr_pick #(
    parameter int N  = 3,
    parameter int SW = 2
) (
    input  logic [N-1:0]  valid_i,
    input  logic [SW-1:0] start_i,
    output logic [N-1:0]  grant_o
);
    logic [2*N-1:0] rot_dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   pick;
    logic [2*N-1:0] back_dbl;

    // Rotate so start_i lands at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot_dbl = {valid_i, valid_i} >> start_i;
        rot     = rot_dbl[N-1:0];
        pick    = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                pick    = '0;
                pick[j] = 1'b1;
            end
        end
        back_dbl = {pick, pick} << start_i;
        grant_o  = back_dbl[2*N-1:N];
    end

endmodule

// File: rtl/exu_wbck_arb.sv
// Writeback arbiter: one register-file write port shared by the ALU (requester 0) and the
// long-pipe sources, with starvation preemption of the ALU and a registered output stage.
module exu_wbck_arb
    import exu_wbck_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int XLEN       = E203_XLEN,
    parameter int RFIDX_W    = E203_RFIDX_WIDTH,
    parameter int STARVE_MAX = E203_WBCK_STARVE_MAX
) (
    input  logic          clk,
    input  logic          rst,
    exu_wbck_arb_if.slave bus
);
    localparam int NLP   = NREQ - 1;
    localparam int PTR_W = idx_width(NREQ);
    localparam int CNT_W = idx_width(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    // rr_ptr holds the requester number 1..NREQ-1; wait counters are indexed by requester-1.
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   wait_q [NLP];
    logic [CNT_W-1:0]   wait_d [NLP];

    logic [NLP-1:0]     lp_valid;
    logic [NLP-1:0]     starve_vec;
    logic [NLP-1:0]     starve_oh;
    logic [NLP-1:0]     rr_grant;
    logic [NLP-1:0]     lp_grant;
    logic [NREQ-1:0]    grant;
    grant_src_e         src;

    logic [RFIDX_W-1:0] win_idx;
    logic [XLEN-1:0]    win_dat;
    logic               xfer;
    logic               wen_q, wen_d;
    logic [RFIDX_W-1:0] idx_q, idx_d;
    logic [XLEN-1:0]    dat_q, dat_d;

    assign lp_valid = bus.req_valid[NREQ-1:1];

    exu_wbck_rr_pick #(.N(NLP), .SW(PTR_W)) u_rr_pick (
        .valid_i (lp_valid),
        .start_i (rr_ptr_q - PTR_W'(1)),
        .grant_o (rr_grant)
    );

    always_comb begin
        starve_vec = '0;
        starve_oh  = '0;
        for (int j = 0; j < NLP; j++) begin
            starve_vec[j] = lp_valid[j] && (wait_q[j] == CNT_MAX);
        end
        for (int j = NLP - 1; j >= 0; j--) begin
            if (starve_vec[j]) begin
                starve_oh    = '0;
                starve_oh[j] = 1'b1;
            end
        end
    end

    always_comb begin
        src      = SRC_NONE;
        lp_grant = '0;
        if (|starve_vec) begin
            src      = SRC_STARVE;
            lp_grant = starve_oh;
        end else if (bus.req_valid[0]) begin
            src = SRC_ALU;
        end else if (|lp_valid) begin
            src      = SRC_RR;
            lp_grant = rr_grant;
        end
        grant = rst ? '0 : {lp_grant, src == SRC_ALU};
    end

    // Winner mux, output-stage next state, pointer and wait-counter updates.
    always_comb begin
        win_idx = '0;
        win_dat = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_idx = bus.req_idx[i*RFIDX_W +: RFIDX_W];
                win_dat = bus.req_dat[i*XLEN +: XLEN];
            end
        end
        xfer  = |grant;
        wen_d = xfer && (win_idx != '0);
        idx_d = xfer ? win_idx : idx_q;
        dat_d = xfer ? win_dat : dat_q;

        rr_ptr_d = rr_ptr_q;
        for (int j = 0; j < NLP; j++) begin
            if (grant[j+1]) begin
                rr_ptr_d = (j == NLP - 1) ? PTR_W'(1) : PTR_W'(j + 2);
            end
            if (grant[j+1] || !lp_valid[j]) begin
                wait_d[j] = '0;
            end else if (wait_q[j] == CNT_MAX) begin
                wait_d[j] = wait_q[j];
            end else begin
                wait_d[j] = wait_q[j] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= PTR_W'(1);
            for (int j = 0; j < NLP; j++) wait_q[j] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int j = 0; j < NLP; j++) wait_q[j] <= wait_d[j];
        end
    end

    // Output stage in load-enable flop style; idx/dat hold when nothing transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q <= 1'b0;
            idx_q <= '0;
            dat_q <= '0;
        end else begin
            wen_q <= wen_d;
            idx_q <= idx_d;
            dat_q <= dat_d;
        end
    end

    assign bus.req_ready     = grant;
    assign bus.starve_evt    = (src == SRC_STARVE) && !rst;
    assign bus.wbck_dest_wen = wen_q;
    assign bus.wbck_dest_idx = idx_q;
    assign bus.wbck_dest_dat = dat_q;

endmodule
